// File: rtl/fixed_point_acc_if.sv
// ---------------------------------------------------------------------------
// fixed_point package and fixed_point_acc_if interface.
//
// The fixed_point package defines the fixed-point data type shared by the
// multiplier and the accumulator: a two's-complement word of `FIXED_W bits.
// `FIXED_FRACTION_W of those bits are fraction bits. Both widths default to
// 32/16 when the build does not already define them.
//
// fixed_point_acc_if bundles both handshakes of the accumulator:
//   in_valid     upstream -> acc   a product is offered this cycle
//   in_ready     acc -> upstream   the product is accepted this cycle
//   in_product   upstream -> acc   product value (fixed_point_t)
//   in_overflow  upstream -> acc   the multiplier overflowed on this product
//   in_last      upstream -> acc   this product is the last term of its group
//   out_valid    acc -> downstream out_sum/out_overflow/out_count are valid
//   out_ready    downstream -> acc the result is taken
//   out_sum      acc -> downstream accumulated sum (fixed_point_t)
//   out_overflow acc -> downstream sticky overflow for the group
//   out_count    acc -> downstream number of terms summed
// The master modport is the producer/consumer side. The slave modport is the
// accumulator side.
// ---------------------------------------------------------------------------
`ifndef FIXED_W
`define FIXED_W 32
`endif
`ifndef FIXED_FRACTION_W
`define FIXED_FRACTION_W 16
`endif

package fixed_point;
    localparam int FRACTION_W = `FIXED_FRACTION_W;
    typedef logic signed [`FIXED_W-1:0] fixed_point_t;
endpackage

interface fixed_point_acc_if #(
    parameter int CNT_W = 3
);
    logic                     in_valid;
    logic                     in_ready;
    fixed_point::fixed_point_t in_product;
    logic                     in_overflow;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    fixed_point::fixed_point_t out_sum;
    logic                     out_overflow;
    logic [CNT_W-1:0]         out_count;

    modport master (
        output in_valid, in_product, in_overflow, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_overflow, out_count
    );

    modport slave (
        input  in_valid, in_product, in_overflow, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_overflow, out_count
    );
endinterface

// File: rtl/fixed_point_acc.sv
// ---------------------------------------------------------------------------
// fixed_point_acc: sequential accumulator placed after the fixed-point
// multiplier.
//
// The block sums one group of products, for example a 3-term dot product.
// A group ends on in_last, or when MAX_TERMS terms have been accepted. The
// block then presents the sum with a sticky overflow flag and the term count.
// It holds that result until downstream takes it.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset; drops any group in flight
//   bus   fixed_point_acc_if.slave (in_* product stream, out_* result)
//
// Optional feature:
//   FIXED_ACC_SATURATE_EN  when defined, the accumulator saturates instead of
//                          wrapping. A positive overflow clamps to 0x7FF..F
//                          and a negative overflow clamps to 0x800..0.
//                          A product flagged in_overflow clamps by the sign
//                          of that product. out_overflow is set in all cases.
// ---------------------------------------------------------------------------
module fixed_point_acc #(
    parameter int MAX_TERMS = 4,
    parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    fixed_point_acc_if.slave      bus
);
    import fixed_point::*;

    localparam int W = `FIXED_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    fixed_point_t     acc;
    fixed_point_t     acc_next;
    fixed_point_t     sum_wrap;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic             ovf;
    logic             accept;
    logic             closing;
    logic             add_ovf;

    // IDLE holds acc = 0 and count = 0. The first beat of a group therefore
    // uses the same adder as every later beat.
    assign accept    = bus.in_valid && bus.in_ready;
    assign count_inc = count + CNT_W'(1);
    assign closing   = bus.in_last || (count_inc == CNT_W'(MAX_TERMS));
    assign sum_wrap  = acc + bus.in_product;
    assign add_ovf   = (acc[W-1] == bus.in_product[W-1]) &&
                       (sum_wrap[W-1] != acc[W-1]);

    always_comb begin
        acc_next = sum_wrap;
`ifdef FIXED_ACC_SATURATE_EN
        // The sign the product was meant to have is lost upstream.
        // Its stored sign is the best available guess.
        if (bus.in_overflow) begin
            acc_next = bus.in_product[W-1] ? fixed_point_t'({1'b1, {(W-1){1'b0}}})
                                           : fixed_point_t'({1'b0, {(W-1){1'b1}}});
        end else if (add_ovf) begin
            acc_next = acc[W-1] ? fixed_point_t'({1'b1, {(W-1){1'b0}}})
                                : fixed_point_t'({1'b0, {(W-1){1'b1}}});
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments. Every flop then
    // samples values from before the edge, whatever order the blocks run in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: each signal written here gets a default before the case statement.
    // A path that skipped the assignment would infer a latch.
    always_comb begin
        state_next     = state;
        bus.in_ready   = 1'b0;
        bus.out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_ready = !rst;
                if (accept) begin
                    state_next = closing ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                bus.in_ready = !rst;
                if (accept && closing) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (accept) begin
            acc   <= acc_next;
            count <= count_inc;
            ovf   <= ovf | bus.in_overflow | add_ovf;
        end else if (state == DONE && bus.out_ready) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end
    end

    assign bus.out_sum      = acc;
    assign bus.out_overflow = ovf;
    assign bus.out_count    = count;

endmodule
